// File: rtl/add8_share_sequencer.sv
// Byte-serial sequencer that time-shares one external 8-bit adder among NREQ
// round-robin requesters; an incoming carry is absorbed by an extra increment pass.
module add8_share_sequencer #(
  parameter int NREQ   = 4,
  parameter int NBYTES = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*8*NBYTES-1:0]  req_a,
  input  logic [NREQ*8*NBYTES-1:0]  req_b,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [1:0]                rsp_id,
  output logic [8*NBYTES-1:0]       rsp_sum,
  output logic                      rsp_carry,
  output logic [7:0]                add_a,
  output logic [7:0]                add_b,
  input  logic [7:0]                add_s,
  input  logic                      add_c
);

  localparam int W  = 8 * NBYTES;
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_INC  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            cin_q, cin_d;
  logic [7:0]      tmp_q, tmp_d;
  logic            c1_q, c1_d;
  logic [W-1:0]    opa_q, opa_d;
  logic [W-1:0]    opb_q, opb_d;
  logic [W-1:0]    sum_q, sum_d;
  logic [1:0]      id_q, id_d;

  logic            gnt_found_s;
  logic [1:0]      gnt_idx_s;
  logic [1:0]      cand_s;
  logic [NREQ-1:0] req_ready_s;
  logic [7:0]      add_a_s;
  logic [7:0]      add_b_s;
  logic            done_s;

  // Round-robin search starting at rr_ptr and wrapping.
  always_comb begin
    gnt_found_s = 1'b0;
    gnt_idx_s   = 2'd0;
    cand_s      = 2'd0;
    for (int k = 0; k < NREQ; k++) begin
      cand_s = rr_ptr_q + 2'(k);
      if (!gnt_found_s && req_valid[cand_s]) begin
        gnt_found_s = 1'b1;
        gnt_idx_s   = cand_s;
      end else begin
        gnt_found_s = gnt_found_s;
      end
    end
  end

  // Next-state, datapath updates and adder operand steering.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    idx_d       = idx_q;
    cin_d       = cin_q;
    tmp_d       = tmp_q;
    c1_d        = c1_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    sum_d       = sum_q;
    id_d        = id_q;
    req_ready_s = {NREQ{1'b0}};
    add_a_s     = 8'h00;
    add_b_s     = 8'h00;

    case (state_q)
      S_IDLE: begin
        if (gnt_found_s) begin
          req_ready_s[gnt_idx_s] = 1'b1;
          opa_d    = req_a[int'(gnt_idx_s)*W +: W];
          opb_d    = req_b[int'(gnt_idx_s)*W +: W];
          id_d     = gnt_idx_s;
          rr_ptr_d = gnt_idx_s + 2'd1;
          idx_d    = {IW{1'b0}};
          cin_d    = 1'b0;
          state_d  = S_ADD;
        end else begin
          state_d  = S_IDLE;
        end
      end

      S_ADD: begin
        add_a_s = opa_q[{idx_q, 3'b000} +: 8];
        add_b_s = opb_q[{idx_q, 3'b000} +: 8];
        if (cin_q) begin
          // Adder has no carry-in: keep the raw byte and finish it in INC.
          tmp_d   = add_s;
          c1_d    = add_c;
          state_d = S_INC;
        end else begin
          sum_d[{idx_q, 3'b000} +: 8] = add_s;
          cin_d = add_c;
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + {{(IW-1){1'b0}}, 1'b1};
          end
        end
      end

      S_INC: begin
        add_a_s = tmp_q;
        add_b_s = 8'h01;
        sum_d[{idx_q, 3'b000} +: 8] = add_s;
        cin_d = c1_q | add_c;
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + {{(IW-1){1'b0}}, 1'b1};
          state_d = S_ADD;
        end
      end

      S_DONE: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= 2'd0;
      idx_q    <= {IW{1'b0}};
      cin_q    <= 1'b0;
      tmp_q    <= 8'h00;
      c1_q     <= 1'b0;
      opa_q    <= {W{1'b0}};
      opb_q    <= {W{1'b0}};
      sum_q    <= {W{1'b0}};
      id_q     <= 2'd0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      idx_q    <= idx_d;
      cin_q    <= cin_d;
      tmp_q    <= tmp_d;
      c1_q     <= c1_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      sum_q    <= sum_d;
      id_q     <= id_d;
    end
  end

  // Outputs are forced low while reset is asserted, whatever the state.
  assign done_s    = rst_n && (state_q == S_DONE);
  assign rsp_valid = done_s;
  assign rsp_id    = done_s ? id_q : 2'd0;
  assign rsp_sum   = done_s ? sum_q : {W{1'b0}};
  assign rsp_carry = done_s ? cin_q : 1'b0;
  assign req_ready = rst_n ? req_ready_s : {NREQ{1'b0}};
  assign add_a     = rst_n ? add_a_s : 8'h00;
  assign add_b     = rst_n ? add_b_s : 8'h00;

endmodule
